// File: rtl/fix_ext.sv
// Streaming fixed-point widener: sign-extends narrow two's-complement samples,
// left-shifts them by FRAC_SHIFT to realign the binary point, and flags rail
// codes (max positive / min negative) that indicate upstream clipping.
// Output register plus a 1-entry skid register; in_ready is "skid empty" and
// never depends combinationally on out_ready.
// Optional: define FIX_EXT_SAT_CNT_EN to build the saturating rail-code counter
// (sat_cnt / sat_clr). Without it sat_cnt is tied to zero and sat_clr ignored.
module fix_ext #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned FRAC_SHIFT = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_sat,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_cnt
);

  if (OUT_WIDTH < IN_WIDTH + FRAC_SHIFT) begin : gen_width_check
    $error("fix_ext: OUT_WIDTH must be >= IN_WIDTH + FRAC_SHIFT");
  end
  if (IN_WIDTH < 2) begin : gen_in_width_check
    $error("fix_ext: IN_WIDTH must be >= 2");
  end

  localparam logic [IN_WIDTH-1:0] RailPos = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic [IN_WIDTH-1:0] RailNeg = {1'b1, {(IN_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] data;
  logic                 rail;
  logic                 accept;
  logic                 drain;

  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 out_sat_q, out_sat_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] skid_q, skid_d;
  logic                 skid_sat_q, skid_sat_d;
  logic                 skid_valid_q, skid_valid_d;

  // Input transform: sign extension then zero-filled left shift.
  always_comb begin
    ext  = OUT_WIDTH'($signed(in));
    data = ext << FRAC_SHIFT;
    rail = (in == RailPos) || (in == RailNeg);
  end

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sat   = out_sat_q;

  // Next state for output and skid stages; skid only fills when output is stuck.
  always_comb begin
    out_d        = out_q;
    out_sat_d    = out_sat_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_sat_d   = skid_sat_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // in_ready is low here, so no new sample competes with the skid entry.
      if (drain) begin
        out_d        = skid_q;
        out_sat_d    = skid_sat_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_d       = data;
        out_sat_d   = rail;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = data;
        skid_sat_d   = rail;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_sat_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_sat_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_sat_q    <= out_sat_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_sat_q   <= skid_sat_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef FIX_EXT_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_event;

  assign sat_event = accept & rail;

  // Saturating counter; a clear coinciding with an event leaves one count.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = sat_event ? CNT_WIDTH'(1) : '0;
    end else if (sat_event && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fix_ext.sv
// Directed self-checking bench for fix_ext (IN=8, OUT=16, FRAC_SHIFT=4, CNT=4).
// Counter expectations follow whether FIX_EXT_SAT_CNT_EN is defined.
module tb_fix_ext;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        out_sat;
  logic        sat_clr;
  logic [3:0]  sat_cnt;

  int n_checks;
  int n_fails;

  fix_ext #(
    .IN_WIDTH  (8),
    .OUT_WIDTH (16),
    .FRAC_SHIFT(4),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_cnt  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_exp(input logic [3:0] v);
`ifdef FIX_EXT_SAT_CNT_EN
    return v;
`else
    return 4'h0;
`endif
  endfunction

  // Present one sample with out_ready high; checks 1-cycle latency and data.
  task automatic send_one(input logic [7:0] x, input logic [15:0] e, input logic es,
                          input string tag);
    in_valid = 1'b1;
    in       = x;
    check({tag, "_pre_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, {16'd0, out}, {16'd0, e});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, es});
    @(posedge clk); #1;
  endtask

  initial begin
    int          idx;
    int          rx;
    logic        saw_stall;
    logic        held;
    logic [15:0] held_val;

    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in        = 8'h00;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_sat_cnt", {28'd0, sat_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transform.
    send_one(8'h85, 16'hF850, 1'b0, "neg85");
    send_one(8'h12, 16'h0120, 1'b0, "pos12");

    // Rail codes.
    send_one(8'h7F, 16'h07F0, 1'b1, "rail7f");
    send_one(8'h80, 16'hF800, 1'b1, "rail80");
    send_one(8'h81, 16'hF810, 1'b0, "near81");
    check("cnt_after_rails", {28'd0, sat_cnt}, {28'd0, cnt_exp(4'd2)});

    // Backpressure: 0x01..0x08 back-to-back, out_ready low in cycles 3..6.
    idx       = 0;
    rx        = 0;
    saw_stall = 1'b0;
    held      = 1'b0;
    held_val  = '0;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (idx < 8);
      in        = 8'(idx + 1);
      if (held) check("bp_stable", {16'd0, out}, {16'd0, held_val});
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        check("bp_order", {16'd0, out}, 32'((rx + 1) << 4));
        rx++;
      end
      held     = out_valid && !out_ready;
      held_val = out;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", rx, 32'd8);
    check("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
    check("bp_idle", {31'd0, out_valid}, 32'd0);

    // Counter saturation: 20 rail samples.
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in       = k[0] ? 8'h80 : 8'h7F;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("cnt_saturated", {28'd0, sat_cnt}, {28'd0, cnt_exp(4'hF)});
    in_valid = 1'b1;
    in       = 8'h7F;
    sat_clr  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("cnt_clr_event", {28'd0, sat_cnt}, {28'd0, cnt_exp(4'd1)});
    check("cnt_clr_out_sat", {31'd0, out_sat}, 32'd1);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("cnt_clr_alone", {28'd0, sat_cnt}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-stream with output and skid full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in        = 8'h7F;
    @(posedge clk); #1;
    in = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_skid_full", {31'd0, in_ready}, 32'd0);
    check("mid_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_sat_cnt", {28'd0, sat_cnt}, 32'd0);
    check("mid_rst_out", {16'd0, out}, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_one(8'h12, 16'h0120, 1'b0, "post_rst");
    check("post_rst_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
